// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides: compare, add/sub, boolean, shift.
// Define ALU_MUL_EN to add a WIDTH-cycle shift-and-add multiplier with a BUSY state.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [5:0]       fn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             z,
   output logic             v,
   output logic             n
);
   localparam int SW = $clog2(WIDTH);

   // Handshake: a transfer happens on a rising edge where valid && ready; the
   // producer holds its payload until then, and ready never waits on valid.
   logic [WIDTH-1:0] out_q, res_d, diff, b_x, sum;
   logic             z_q, v_q, n_q, out_valid_q, v_d;
   logic             cmp_eq, cmp_lt, cmp_bit;
   logic [SW-1:0]    sh;
   logic [3:0]       tt;
   logic             accept, mul_sel;

`ifdef ALU_MUL_EN
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   state_t           state_q;
   logic [SW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_q, ma_q, mb_q, acc_d;

   assign mul_sel  = (fn[5:4] == 2'b01) && fn[1];
   assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign acc_d    = mb_q[cnt_q] ? acc_q + (ma_q << cnt_q) : acc_q;
`else
   assign mul_sel  = 1'b0;
   assign in_ready = !out_valid_q || out_ready;
`endif

   assign accept    = in_valid && in_ready;
   assign out       = out_q;
   assign z         = z_q;
   assign v         = v_q;
   assign n         = n_q;
   assign out_valid = out_valid_q;

   always_comb begin
      diff    = a - b;
      cmp_eq  = (diff == '0);
      // Signed less-than is V xor N of the subtraction.
      cmp_lt  = ((a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])) ^ diff[WIDTH-1];
      b_x     = b ^ {WIDTH{fn[0]}};
      sum     = a + b_x + {{(WIDTH-1){1'b0}}, fn[0]};
      sh      = b[SW-1:0];
      tt      = fn[3:0];
      cmp_bit = 1'b0;
      res_d   = '0;
      v_d     = 1'b0;
      case (fn[5:4])
         2'b00: begin
            case (fn[2:1])
               2'b01:   cmp_bit = cmp_eq;
               2'b10:   cmp_bit = cmp_lt;
               2'b11:   cmp_bit = cmp_eq | cmp_lt;
               default: cmp_bit = 1'b0;
            endcase
            res_d = {{(WIDTH-1){1'b0}}, cmp_bit};
         end
         2'b01: begin
            res_d = sum;
            v_d   = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         2'b10: begin
            for (int i = 0; i < WIDTH; i++) res_d[i] = tt[{b[i], a[i]}];
         end
         default: begin
            case (fn[1:0])
               2'b00:   res_d = a << sh;
               2'b01:   res_d = a >> sh;
               2'b11:   res_d = $unsigned($signed(a) >>> sh);
               default: res_d = '0;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         z_q         <= 1'b0;
         v_q         <= 1'b0;
         n_q         <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         ma_q        <= '0;
         mb_q        <= '0;
`endif
      end else begin
         if (out_valid_q && out_ready) out_valid_q <= 1'b0;
         // A new single-cycle result overrides the consume on the same edge.
         if (accept && !mul_sel) begin
            out_q       <= res_d;
            z_q         <= (res_d == '0);
            v_q         <= v_d;
            n_q         <= res_d[WIDTH-1];
            out_valid_q <= 1'b1;
         end
`ifdef ALU_MUL_EN
         case (state_q)
            IDLE: begin
               if (accept && mul_sel) begin
                  state_q <= BUSY;
                  ma_q    <= a;
                  mb_q    <= b;
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            BUSY: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == SW'(WIDTH - 1)) begin
                  state_q     <= IDLE;
                  out_q       <= acc_d;
                  z_q         <= (acc_d == '0);
                  v_q         <= 1'b0;
                  n_q         <= acc_d[WIDTH-1];
                  out_valid_q <= 1'b1;
               end
            end
         endcase
`endif
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with literal expectations plus randomized traffic
// scored against a transaction-level model (expected result queue with visibility times).
module tb_alu_seq;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         in_ready, out_valid, z, v, n;
   logic [W-1:0] a = '0, b = '0, out;
   logic [5:0]   fn = '0;

   int           n_vec = 0;
   int           n_err = 0;
   int           cyc = 0;
   logic [W+2:0] exp_q[$];   // {n, v, z, result}
   int           vis_q[$];   // cycle count at which each result becomes visible
   logic         last_in_ready = 1'b0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .fn(fn), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .z(z), .v(v), .n(n)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference result straight from the operation definitions, using wide signed arithmetic.
   function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic [5:0] f, output bit is_mul);
      longint       sa, sb, s;
      logic [W-1:0] r;
      logic         ov;
      int           sh;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      r = '0;
      ov = 1'b0;
      is_mul = 1'b0;
      sh = int'(mb[4:0]);
      case (f[5:4])
         2'b00: begin
            case (f[2:1])
               2'b01: if (ma == mb) r = 32'd1;
               2'b10: if (sa < sb) r = 32'd1;
               2'b11: if (sa <= sb) r = 32'd1;
               default: r = '0;
            endcase
         end
         2'b01: begin
            s = f[0] ? sa - sb : sa + sb;
            r = s[31:0];
            ov = (s != longint'($signed(r)));
`ifdef ALU_MUL_EN
            if (f[1]) begin
               logic [63:0] p;
               p = 64'(ma) * 64'(mb);
               r = p[31:0];
               ov = 1'b0;
               is_mul = 1'b1;
            end
`endif
         end
         2'b10: begin
            for (int i = 0; i < W; i++) r[i] = f[{mb[i], ma[i]}];
         end
         default: begin
            case (f[1:0])
               2'b00: r = ma << sh;
               2'b01: r = ma >> sh;
               2'b11: begin s = sa >>> sh; r = s[31:0]; end
               default: r = '0;
            endcase
         end
      endcase
      return {r[W-1], ov, (r == '0), r};
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return W'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   // One clock cycle, entered and left at a falling edge: check outputs, drive, score handshakes.
   task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [5:0] ifn, input logic ordy);
      logic [W+2:0] e;
      bit           mul, exp_valid, busy, exp_rdy;
      exp_valid = (exp_q.size() > 0) && (vis_q[0] <= cyc);
      busy = (vis_q.size() > 0) && (vis_q[vis_q.size()-1] > cyc);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
         e = exp_q[0];
         chk("out", out, e[W-1:0]);
         chk("z", z, e[W]);
         chk("v", v, e[W+1]);
         chk("n", n, e[W+2]);
      end
      in_valid = iv;
      a = ia;
      b = ib;
      fn = ifn;
      out_ready = ordy;
      #1;
      exp_rdy = !busy && (!exp_valid || ordy);
      last_in_ready = in_ready;
      chk("in_ready", in_ready, exp_rdy);
      if (exp_valid && ordy) begin
         void'(exp_q.pop_front());
         void'(vis_q.pop_front());
      end
      if (iv && exp_rdy) begin
         e = model(ia, ib, ifn, mul);
         exp_q.push_back(e);
         vis_q.push_back(cyc + 1 + (mul ? W : 0));
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst out_valid", out_valid, 32'd0);
      chk("rst out", out, 32'd0);
      chk("rst zvn", {z, v, n}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst in_ready", in_ready, 32'd1);
      @(negedge clk);

      step(1'b1, 32'h7FFF_FFFF, 32'h1, 6'b010000, 1'b1);
      chk("add ovf out", out, 32'h8000_0000);
      chk("add ovf flags vnz", {v, n, z}, 32'd6);
      chk("add ovf valid", out_valid, 32'd1);

      step(1'b1, 32'hFFFF_FFFF, 32'h1, 6'b000100, 1'b1);
      chk("cmp lt out", out, 32'd1);
      step(1'b1, 32'h1234, 32'h1234, 6'b000010, 1'b1);
      chk("cmp eq out", out, 32'd1);
      chk("cmp eq z", z, 32'd0);

      step(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 6'b100110, 1'b1);
      chk("xor out", out, 32'h0FF0_0FF0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, $urandom, $urandom, 6'b010000, 1'b0);
         chk("hold in_ready", last_in_ready, 32'd0);
         chk("hold out", out, 32'h0FF0_0FF0);
      end
      step(1'b1, 32'd2, 32'd3, 6'b010000, 1'b1);
      chk("overlap in_ready", last_in_ready, 32'd1);
      chk("overlap out", out, 32'd5);

      step(1'b1, 32'h8000_0000, 32'h24, 6'b110011, 1'b1);
      chk("sra out", out, 32'hF800_0000);
      step(1'b1, 32'h8000_0000, 32'h24, 6'b110001, 1'b1);
      chk("srl out", out, 32'h0800_0000);

      step(1'b1, 32'd12345, 32'd6789, 6'b010010, 1'b1);
`ifdef ALU_MUL_EN
      begin : mul_wait
         int   lat;
         logic saw_rdy;
         lat = 0;
         saw_rdy = 1'b0;
         while (out_valid !== 1'b1 && lat < 40) begin
            step(1'b1, $urandom, $urandom, 6'b100110, 1'b1);
            lat++;
            if (last_in_ready) saw_rdy = 1'b1;
         end
         chk("mul latency", lat, 32'd32);
         chk("mul in_ready low", saw_rdy, 32'd0);
         chk("mul out", out, 32'd83810205);
         chk("mul v", v, 32'd0);
      end
`else
      chk("mul-off add out", out, 32'd19134);
      chk("mul-off v", v, 32'd0);
`endif

      step(1'b1, $urandom, $urandom, 6'b010010, 1'b1);
      repeat (9) step(1'b0, '0, '0, 6'b000000, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort out_valid", out_valid, 32'd0);
      chk("abort out", out, 32'd0);
      exp_q.delete();
      vis_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 32'd2, 32'd3, 6'b010000, 1'b1);
      chk("post-abort in_ready", last_in_ready, 32'd1);
      chk("post-abort out", out, 32'd5);

      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(0, 3) != 0), pick(), pick(), 6'($urandom_range(0, 63)),
              ($urandom_range(0, 3) != 0));
      end
      repeat (40) step(1'b0, '0, '0, 6'b000000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshaked successor to the combinational WIDTH-bit ALU. Same 6-bit function encoding and same four operation groups: compare, add/sub, bitwise boolean and shift. Adds:
- valid/ready flow control on input and output,
- registered Z/V/N flags,
- an optional iterative multiplier.

It sits between the operand-fetch stage and the writeback stage of the datapath.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 4; shift amount is b[$clog2(WIDTH)-1:0]
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand/function presented
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- fn  input  6  function code
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  registered result
- z, v, n  output  1 each  registered zero / overflow / negative flags

## Operation
- Group select is fn[5:4]:
  - 00 compare
  - 01 arithmetic
  - 10 boolean
  - 11 shift
- Compare: computes a−b internally.
  - LT = V^N; LE = Z|LT.
  - fn[2:1]: 01 EQ, 10 LT, 11 LE, 00 yields 0.
  - out is {WIDTH-1 zeros, bit}.
- Arithmetic:
  - fn[0]=0 gives a+b; fn[0]=1 gives a−b, modulo 2^WIDTH.
  - V = signed overflow: sign(a)==sign(b^{fn[0]}) and sign(out) differs.
  - fn[1]=1 selects MUL when compiled in; see Configuration.
- Boolean: out[i] = fn[{b[i],a[i]}], i.e. fn[3:0] is the truth table (0110 XOR, 1000 AND, 1110 OR).
- Shift, amount s = b[$clog2(WIDTH)-1:0]:
  - fn[1:0] 00 gives a<<s.
  - fn[1:0] 01 gives logical a>>s.
  - fn[1:0] 11 gives arithmetic a>>>s (sign-filled).
  - fn[1:0] 10 yields 0.
- Flags for every op:
  - z = (out==0).
  - n = out[WIDTH-1].
  - v = the add/sub overflow for arithmetic add/sub; 0 for all other ops, including MUL and compare.
- State machine:
  - IDLE: waiting for an input, or holding a result.
  - BUSY: multiply iterating; counter runs 0..WIDTH-1.
- Transitions:
  - Accept of a non-MUL op: stay IDLE; result and flags registered on the accept edge.
  - Accept of MUL: go to BUSY. Latch a, b; clear the accumulator.
  - BUSY: each edge, if multiplier bit b[cnt] is 1, add a<<cnt to the accumulator.
  - BUSY after the edge with cnt==WIDTH-1: write the low WIDTH bits of the product to out, set out_valid, return to IDLE.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational from state and out_ready.
- Result consumed when out_valid && out_ready.
  - out_valid clears on that edge unless a new non-MUL op is accepted on the same edge. In that case out_valid stays 1 with the new result.
- While out_valid=1 and out_ready=0, out, z, v and n hold steady.
- a, b and fn are don't-care when no accept occurs.

## Timing
- Reset (rst_n low, async):
  - state IDLE, counter 0, accumulator 0.
  - out 0; z, v, n 0; out_valid 0.
  - in_ready 1 once reset is released.
- Non-MUL latency: accept at edge E; out_valid=1 and result visible after E. Sustained throughput is 1 op/cycle with out_ready held high.
- MUL latency: accept at edge E; out_valid=1 after edge E+WIDTH. in_ready=0 from after E until the result is consumed.
- Simultaneous output consume and input accept on one edge is legal and loses no data.
- Reset asserted during BUSY: the operation is aborted and no result is produced.

## Configuration
- Macro ALU_MUL_EN.
- Defined: fn[5:4]=01 with fn[1]=1 is MUL and fn[0] is ignored. The BUSY state, counter and accumulator are present.
- Undefined:
  - fn[1] is ignored in the arithmetic group, so the op is add/sub per fn[0].
  - No BUSY state exists; in_ready = !out_valid || out_ready.
  - Every op has 1-cycle latency.

## Test plan
- ADD overflow: fn=010000, a=0x7FFFFFFF, b=1 -> one cycle later out=0x80000000, v=1, n=1, z=0, out_valid=1.
- Compare LT: fn=000100, a=0xFFFFFFFF, b=1 -> out=1. Then fn=000010, a=b=0x1234 -> out=1, z=0.
- Boolean and backpressure: fn=100110, a=0xF0F0F0F0, b=0xFF00FF00 -> out=0x0FF00FF0. Hold out_ready=0 for 5 cycles -> out stable, in_ready=0. Raise out_ready with a new op presented -> both handshakes complete on the same edge.
- Shift: fn=110011, a=0x80000000, b=0x24 -> out=0xF8000000 (s=4). fn=110001 with the same operands -> out=0x08000000.
- MUL (ALU_MUL_EN): fn=010010, a=12345, b=6789 -> out=83810205, v=0, out_valid exactly 32 edges after accept, in_ready=0 throughout. Without the macro the same stimulus -> out=19134 after 1 cycle.
- Reset mid-MUL: drop rst_n 10 cycles after MUL accept -> out_valid=0 and out=0 immediately. After release, in_ready=1 and the next ADD 2+3 -> out=5.
